// File: rtl/calc_display_seq_pkg.sv
// Shared types and constants for the calculator display sequencer:
// status codes, display glyphs and the sequencer state encoding.
package calc_display_seq_pkg;

  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_PRINT = 2'b11
  } status_e;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONV     = 3'd1,
    S_EMIT     = 3'd2,
    S_EMIT_ERR = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // Largest value that fits on ndig decimal digits (10^ndig - 1).
  function automatic logic [63:0] max_decimal(input int ndig);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < ndig; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/calc_display_seq_if.sv
// Print request / digit stream bundle between the calc datapath, the
// display sequencer and the display driver.
interface calc_display_seq_if #(parameter int W = 27);
  logic         start;
  logic [W-1:0] value;
  logic         err;
  logic         busy;
  logic         valid;
  logic [3:0]   data;
  logic [3:0]   pos;
  logic         done;
  logic [1:0]   status;

  modport master (
    output start, value, err,
    input  busy, valid, data, pos, done, status
  );

  modport slave (
    input  start, value, err,
    output busy, valid, data, pos, done, status
  );
endinterface

// File: rtl/calc_display_seq_bcd_dd_step.sv
// One combinational double-dabble iteration over a {bcd, binary} shift register:
// add 3 to every BCD nibble >= 5, then shift the whole register left by one.
module bcd_dd_step #(
  parameter int W    = 27,
  parameter int NDIG = 8
) (
  input  logic [W+4*NDIG-1:0] sr_i,
  output logic [W+4*NDIG-1:0] sr_o
);

  localparam int SRW = W + 4 * NDIG;

  logic [SRW-1:0] adj_s;

  always_comb begin
    adj_s = sr_i;
    for (int i = 0; i < NDIG; i++) begin
      if (sr_i[W+4*i +: 4] >= 4'd5) begin
        adj_s[W+4*i +: 4] = sr_i[W+4*i +: 4] + 4'd3;
      end else begin
        adj_s[W+4*i +: 4] = sr_i[W+4*i +: 4];
      end
    end
  end

  assign sr_o = {adj_s[SRW-2:0], 1'b0};

endmodule

// File: rtl/calc_display_seq.sv
// Display sequencer: captures a binary value on an accepted start, converts it to
// BCD one double-dabble step per cycle, then streams one digit per cycle.
module calc_display_seq
  import calc_display_seq_pkg::*;
#(
  parameter int W        = 27,
  parameter int NDIG     = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic             clock,
  input logic             reset,
  calc_display_seq_if.slave bus
);

  localparam int          SRW     = W + 4 * NDIG;
  localparam int          CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [63:0] MAX_VAL = max_decimal(NDIG);

  state_e         state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d, step_s;
  logic [CW-1:0]  it_q, it_d;
  logic           busy_q, busy_d, valid_q, valid_d, done_q, done_d;
  logic [3:0]     data_q, data_d, pos_q, pos_d;
  status_e        status_q, status_d;

  // Digit k of the BCD word, blanked when it sits above the most significant nonzero digit.
  function automatic logic [3:0] digit_sel(input logic [4*NDIG-1:0] bcd, input logic [3:0] k);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < NDIG; j++) begin
      if (j >= int'(k) && bcd[4*j +: 4] != 4'd0) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    if (BLANK_LZ && k != 4'd0 && !nz) begin
      return DIG_BLANK;
    end else begin
      return bcd[4*k +: 4];
    end
  endfunction

  bcd_dd_step #(.W(W), .NDIG(NDIG)) u_step (
    .sr_i (sr_q),
    .sr_o (step_s)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    it_d     = it_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    data_d   = data_q;
    pos_d    = pos_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.err || (64'(bus.value) > MAX_VAL)) begin
            state_d  = S_EMIT_ERR;
            valid_d  = 1'b1;
            data_d   = DIG_ERR;
            pos_d    = 4'd0;
            status_d = ST_ERR;
          end else begin
            state_d  = S_CONV;
            sr_d     = {{(4*NDIG){1'b0}}, bus.value};
            it_d     = {CW{1'b0}};
            status_d = ST_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // The last iteration's result feeds digit 0 directly so it appears the next cycle.
      S_CONV: begin
        sr_d = step_s;
        if (it_q == CW'(W - 1)) begin
          state_d  = S_EMIT;
          valid_d  = 1'b1;
          data_d   = digit_sel(step_s[SRW-1:W], 4'd0);
          pos_d    = 4'd0;
          status_d = ST_PRINT;
        end else begin
          it_d = it_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_EMIT: begin
        if (pos_q == 4'(NDIG - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = ST_READY;
        end else begin
          valid_d = 1'b1;
          pos_d   = pos_q + 4'd1;
          data_d  = digit_sel(sr_q[SRW-1:W], pos_q + 4'd1);
        end
      end
      // Error status stays 00 through DONE and IDLE until the next accepted start.
      S_EMIT_ERR: begin
        if (pos_q == 4'(NDIG - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
          pos_d   = pos_q + 4'd1;
          data_d  = DIG_BLANK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        status_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= {SRW{1'b0}};
      it_q     <= {CW{1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 4'd0;
      pos_q    <= 4'd0;
      status_q <= ST_READY;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      it_q     <= it_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      data_q   <= data_d;
      pos_q    <= pos_d;
      status_q <= status_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.done   = done_q;
  assign bus.data   = data_q;
  assign bus.pos    = pos_q;
  assign bus.status = status_q;

endmodule
